// File: rtl/rr_port_arbiter.sv
// rr_port_arbiter: round-robin output-port arbiter for the NOC router.
// One instance per output port. Inputs whose next-hop address matches PORT_ID
// compete. A rotating pointer picks the winner, and the grant is held until
// the crossbar pulses release_i at the packet tail.
// Optional feature macro: RR_ARB_TIMEOUT_EN (forced release after MAX_HOLD cycles).
module rr_port_arbiter #(
  parameter int                NUM_REQ  = 4,
  parameter int                ADDR_W   = 3,
  parameter logic [ADDR_W-1:0] PORT_ID  = 3'd1,
  parameter int                MAX_HOLD = 16,
  parameter int                IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_nexthop_addr_i,
  input  logic                      release_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [IDX_W-1:0]          grant_idx_o,
  output logic                      grant_valid_o,
  output logic                      timeout_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     ptr, ptr_nxt, ptr_inc;
  logic [NUM_REQ-1:0]   grant_q, grant_nxt;
  logic [IDX_W-1:0]     idx_q, idx_nxt;
  logic [NUM_REQ-1:0]   desire;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand;
  int                   scan;
  logic                 forced;
  logic                 pkt_end;

  if (MAX_HOLD < 2) begin : g_max_hold_chk
    $error("rr_port_arbiter: MAX_HOLD must be at least 2");
  end

  // Per-input request filter: valid head flit heading to this port.
  always_comb begin
    desire = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      desire[i] = req_valid_i[i] &&
                  (req_nexthop_addr_i[i*ADDR_W +: ADDR_W] == PORT_ID);
    end
  end

  // Rotating-priority scan: walk from ptr upward; the smallest offset wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan = int'(ptr) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      cand = IDX_W'(scan);
      if (desire[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Winner+1 with explicit wrap so ptr never leaves 0..NUM_REQ-1.
  assign ptr_inc = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  // A packet ends on an explicit release or a forced (timeout) release.
  assign pkt_end = (state == BUSY) && (release_i || forced);

  // State register plus registered grant outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      grant_q <= '0;
      idx_q   <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      grant_q <= grant_nxt;
      idx_q   <= idx_nxt;
    end
  end

  // Next-state: IDLE grants when anyone desires; BUSY leaves only at packet end.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = BUSY;
      BUSY:    if (pkt_end)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/pointer next values: load on grant, clear grant and rotate on release.
  always_comb begin
    ptr_nxt   = ptr;
    grant_nxt = grant_q;
    idx_nxt   = idx_q;
    if (state == IDLE && win_found) begin
      grant_nxt          = '0;
      grant_nxt[win_idx] = 1'b1;
      idx_nxt            = win_idx;
    end else if (pkt_end) begin
      grant_nxt = '0;
      ptr_nxt   = ptr_inc;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  assign forced = (state == BUSY) && !release_i &&
                  (hold_cnt == CNT_W'(MAX_HOLD - 1));

  // Hold counter: zero while idle/at grant, counts BUSY cycles, emits timeout pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= forced;
      if (state != BUSY || pkt_end) hold_cnt <= '0;
      else                          hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign forced    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign grant_o       = grant_q;
  assign grant_idx_o   = idx_q;
  assign grant_valid_o = (state == BUSY);

endmodule
